scan_select_sequencer: RTL

Sequential front end that generates the 3-bit select (`a`, `b`, `c`) and the enable (`en`) for the 3-to-8 line decoder. It walks the select through codes 0..7 with a programmable dwell per code. A one-cycle blanking gap between codes ensures no two decoder outputs are ever active in the same cycle. It supports free-running scan, single-step scan, and a directed start code loaded while idle.

---
 rtl/scan_select_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/scan_select_sequencer.sv
// Select/enable sequencer for a 3-to-8 decoder: walks codes 0..7 with a
// programmable dwell per code and a one-cycle blank between codes.
module scan_select_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               step_mode,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [2:0]         load_sel,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               en,
    output logic               busy,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] dwell_eff;

    // A dwell of 0 still drives the code for one cycle.
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            if (state_q == IDLE && load) sel_d = load_sel;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) sel_d = load_sel;
                    if (start) begin
                        state_d = DRIVE;
                        cnt_d   = dwell_eff;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                DRIVE: begin
                    if (step_mode) begin
                        // Count is held so switching back to auto resumes it.
                        if (step) begin
                            state_d = BLANK;
                            en_d    = 1'b0;
                        end
                    end else if (cnt_q <= DWELL_W'(1)) begin
                        state_d = BLANK;
                        en_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                BLANK: begin
                    // Advance on the way out so a stop during blank keeps the code.
                    state_d = DRIVE;
                    sel_d   = sel_q + 3'd1;
                    cnt_d   = dwell_eff;
                    en_d    = 1'b1;
                    wrap_d  = (sel_q == 3'd7);
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign a    = sel_q[2];
    assign b    = sel_q[1];
    assign c    = sel_q[0];
    assign en   = en_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule
